i2c_target_responder: RTL and testbench

Synchronous I2C target (slave) that answers the APB-to-I2C bridge on the shared open-drain SDA/SCL bus.
- Oversamples SCL/SDA on Pclk, detects START/STOP, decodes the 7-bit address and R/W bit, and ACKs only its own address.
- Serves writes and reads from an internal byte memory with an auto-incrementing pointer.
- Used as the bus-side counterpart in bridge regressions and as the reusable target RTL.

---
 rtl/i2c_target_responder_if.sv | 30 +++
 rtl/i2c_target_responder.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_responder_if.sv
// Bus-side interface of i2c_target_responder.
// Carries the raw SCL/SDA levels into the target, plus the open-drain
// pull-down enables and the receive/status outputs coming back from it.
interface i2c_target_responder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 16
);
   localparam int PTR_W = $clog2(MEM_DEPTH);

   logic                  scl_in;
   logic                  sda_in;
   logic                  sda_oe;
   logic                  scl_oe;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  busy;
   logic [PTR_W-1:0]      mem_ptr;

   // The target responder side.
   modport slave (
      input  scl_in, sda_in,
      output sda_oe, scl_oe, rx_data, rx_valid, busy, mem_ptr
   );

   // The bus model / controller side.
   modport master (
      output scl_in, sda_in,
      input  sda_oe, scl_oe, rx_data, rx_valid, busy, mem_ptr
   );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target responder: oversamples SCL/SDA on Pclk, detects START/STOP,
// ACKs only TARGET_ADDR, and serves writes/reads from a small byte memory
// with an auto-incrementing pointer. A write first sets the pointer, then
// stores bytes; a read streams bytes starting at the pointer.
// Optional clock stretching after each acknowledge slot is enabled by
// defining I2C_TARGET_CLK_STRETCH_EN; otherwise scl_oe is tied low.
module i2c_target_responder #(
   parameter int                    ADDR_WIDTH     = 7,
   parameter int                    DATA_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h50,
   parameter int                    MEM_DEPTH      = 16,
   parameter int                    STRETCH_CYCLES = 8
) (
   input  logic                  Pclk,
   input  logic                  Presetn,
   i2c_target_responder_if.slave bus
);
   localparam int             PTR_W    = $clog2(MEM_DEPTH);
   localparam int             BCW      = $clog2(DATA_WIDTH + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0] FULL_CNT = BCW'(DATA_WIDTH);

   // Reject parameter sets the datapath cannot represent.
   if (((MEM_DEPTH & (MEM_DEPTH - 1)) != 0) || (MEM_DEPTH > (1 << DATA_WIDTH)) ||
       (STRETCH_CYCLES < 1) || (ADDR_WIDTH != DATA_WIDTH - 1)) begin : g_bad_cfg
      $error("i2c_target_responder: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      PTR      = 3'd3,
      WR_DATA  = 3'd4,
      WR_ACK   = 3'd5,
      RD_DATA  = 3'd6,
      RD_ACK   = 3'd7
   } state_t;

   state_t                state_r, state_s;
   logic                  scl_s1_r, scl_s2_r, scl_d_r;
   logic                  sda_s1_r, sda_s2_r, sda_d_r;
   logic [BCW-1:0]        bit_cnt_r, bit_cnt_s;
   logic [DATA_WIDTH-1:0] shift_r, shift_s;
   logic                  phase_r, phase_s;
   logic                  mack_r, mack_s;
   logic                  sda_oe_r, sda_oe_s;
   logic                  busy_r, busy_s;
   logic [PTR_W-1:0]      ptr_r, ptr_s;
   logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
   logic                  rx_valid_r, rx_valid_s;
   logic                  mem_we_s;
   logic [DATA_WIDTH-1:0] rx_byte_s;
   logic [DATA_WIDTH-1:0] rd_byte_s;
   logic                  hold_s;
   logic                  scl_rise_s, scl_fall_s, start_s, stop_s;
   logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

   // Two-flop synchronizers plus one history flop each; idle bus level is 1.
   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         scl_s1_r <= 1'b1;
         scl_s2_r <= 1'b1;
         scl_d_r  <= 1'b1;
         sda_s1_r <= 1'b1;
         sda_s2_r <= 1'b1;
         sda_d_r  <= 1'b1;
      end else begin
         scl_s1_r <= bus.scl_in;
         scl_s2_r <= scl_s1_r;
         scl_d_r  <= scl_s2_r;
         sda_s1_r <= bus.sda_in;
         sda_s2_r <= sda_s1_r;
         sda_d_r  <= sda_s2_r;
      end
   end

   // While we stretch, no SCL edge is acted on.
   assign scl_rise_s = scl_s2_r & ~scl_d_r & ~hold_s;
   assign scl_fall_s = ~scl_s2_r & scl_d_r & ~hold_s;
   assign start_s    = scl_s2_r & scl_d_r & sda_d_r & ~sda_s2_r;
   assign stop_s     = scl_s2_r & scl_d_r & ~sda_d_r & sda_s2_r;
   assign rx_byte_s  = {shift_r[DATA_WIDTH-2:0], sda_s2_r};
   assign rd_byte_s  = mem_r[ptr_r];

`ifdef I2C_TARGET_CLK_STRETCH_EN
   localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
   logic           scl_oe_r;
   logic [SCW-1:0] stretch_cnt_r;
   logic           slot_end_s;

   // The SCL fall that closes the 9th clock of any acknowledge slot.
   assign slot_end_s = scl_fall_s & phase_r & ~start_s & ~stop_s &
                       ((state_r == ADDR_ACK) || (state_r == WR_ACK) || (state_r == RD_ACK));
   assign hold_s     = scl_oe_r;
   assign bus.scl_oe = scl_oe_r;

   // Hold SCL low for STRETCH_CYCLES Pclk cycles after each acknowledge slot.
   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         scl_oe_r      <= 1'b0;
         stretch_cnt_r <= {SCW{1'b0}};
      end else if (start_s || stop_s) begin
         scl_oe_r      <= 1'b0;
         stretch_cnt_r <= {SCW{1'b0}};
      end else if (slot_end_s) begin
         scl_oe_r      <= 1'b1;
         stretch_cnt_r <= SCW'(STRETCH_CYCLES - 1);
      end else if (scl_oe_r) begin
         if (stretch_cnt_r == {SCW{1'b0}}) begin
            scl_oe_r <= 1'b0;
         end else begin
            stretch_cnt_r <= stretch_cnt_r - SCW'(1);
         end
      end else begin
         scl_oe_r <= 1'b0;
      end
   end
`else
   assign hold_s     = 1'b0;
   assign bus.scl_oe = 1'b0;
`endif

   // State and datapath registers; memory is intentionally not part of reset.
   always_ff @(posedge Pclk or negedge Presetn) begin
      if (!Presetn) begin
         state_r    <= IDLE;
         bit_cnt_r  <= {BCW{1'b0}};
         shift_r    <= {DATA_WIDTH{1'b0}};
         phase_r    <= 1'b0;
         mack_r     <= 1'b1;
         sda_oe_r   <= 1'b0;
         busy_r     <= 1'b0;
         ptr_r      <= {PTR_W{1'b0}};
         rx_data_r  <= {DATA_WIDTH{1'b0}};
         rx_valid_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         bit_cnt_r  <= bit_cnt_s;
         shift_r    <= shift_s;
         phase_r    <= phase_s;
         mack_r     <= mack_s;
         sda_oe_r   <= sda_oe_s;
         busy_r     <= busy_s;
         ptr_r      <= ptr_s;
         rx_data_r  <= rx_data_s;
         rx_valid_r <= rx_valid_s;
      end
   end

   // Next-state and output decode; phase_r marks the second half of an ACK slot.
   always_comb begin
      state_s    = state_r;
      bit_cnt_s  = bit_cnt_r;
      shift_s    = shift_r;
      phase_s    = phase_r;
      mack_s     = mack_r;
      sda_oe_s   = sda_oe_r;
      busy_s     = busy_r;
      ptr_s      = ptr_r;
      rx_data_s  = rx_data_r;
      rx_valid_s = 1'b0;
      mem_we_s   = 1'b0;
      if (start_s || stop_s) begin
         state_s   = start_s ? ADDR : IDLE;
         bit_cnt_s = {BCW{1'b0}};
         phase_s   = 1'b0;
         sda_oe_s  = 1'b0;
         busy_s    = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               sda_oe_s = 1'b0;
            end
            ADDR: begin
               if (scl_rise_s) begin
                  shift_s = rx_byte_s;
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_s = {BCW{1'b0}};
                     phase_s   = 1'b0;
                     if (rx_byte_s[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) begin
                        state_s = ADDR_ACK;
                        busy_s  = 1'b1;
                     end else begin
                        state_s = IDLE;
                     end
                  end else begin
                     bit_cnt_s = bit_cnt_r + BCW'(1);
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r;
               end
            end
            ADDR_ACK, WR_ACK: begin
               if (scl_fall_s) begin
                  if (!phase_r) begin
                     sda_oe_s = 1'b1;
                     phase_s  = 1'b1;
                  end else begin
                     phase_s   = 1'b0;
                     bit_cnt_s = {BCW{1'b0}};
                     if (state_r == WR_ACK) begin
                        state_s  = WR_DATA;
                        sda_oe_s = 1'b0;
                     end else if (shift_r[0]) begin
                        state_s  = RD_DATA;
                        shift_s  = rd_byte_s;
                        sda_oe_s = ~rd_byte_s[DATA_WIDTH-1];
                     end else begin
                        state_s  = PTR;
                        sda_oe_s = 1'b0;
                     end
                  end
               end else begin
                  phase_s = phase_r;
               end
            end
            PTR, WR_DATA: begin
               if (scl_rise_s) begin
                  shift_s = rx_byte_s;
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_s = {BCW{1'b0}};
                     phase_s   = 1'b0;
                     state_s   = WR_ACK;
                     if (state_r == PTR) begin
                        ptr_s = rx_byte_s[PTR_W-1:0];
                     end else begin
                        mem_we_s   = 1'b1;
                        rx_data_s  = rx_byte_s;
                        rx_valid_s = 1'b1;
                        ptr_s      = ptr_r + PTR_W'(1);
                     end
                  end else begin
                     bit_cnt_s = bit_cnt_r + BCW'(1);
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r;
               end
            end
            RD_DATA: begin
               if (scl_rise_s) begin
                  bit_cnt_s = bit_cnt_r + BCW'(1);
               end else if (scl_fall_s) begin
                  if (bit_cnt_r == FULL_CNT) begin
                     sda_oe_s  = 1'b0;
                     ptr_s     = ptr_r + PTR_W'(1);
                     bit_cnt_s = {BCW{1'b0}};
                     phase_s   = 1'b0;
                     state_s   = RD_ACK;
                  end else begin
                     shift_s  = {shift_r[DATA_WIDTH-2:0], 1'b0};
                     sda_oe_s = ~shift_r[DATA_WIDTH-2];
                  end
               end else begin
                  bit_cnt_s = bit_cnt_r;
               end
            end
            RD_ACK: begin
               if (scl_rise_s) begin
                  mack_s  = sda_s2_r;
                  phase_s = 1'b1;
               end else if (scl_fall_s && phase_r) begin
                  phase_s = 1'b0;
                  if (!mack_r) begin
                     state_s  = RD_DATA;
                     shift_s  = rd_byte_s;
                     sda_oe_s = ~rd_byte_s[DATA_WIDTH-1];
                  end else begin
                     state_s  = IDLE;
                     sda_oe_s = 1'b0;
                  end
               end else begin
                  phase_s = phase_r;
               end
            end
            default: begin
               state_s  = IDLE;
               sda_oe_s = 1'b0;
            end
         endcase
      end
   end

   // Byte store written at the 8th data bit; contents survive reset.
   always_ff @(posedge Pclk) begin
      if (mem_we_s) begin
         mem_r[ptr_r] <= rx_byte_s;
      end
   end

   assign bus.sda_oe   = sda_oe_r;
   assign bus.rx_data  = rx_data_r;
   assign bus.rx_valid = rx_valid_r;
   assign bus.busy     = busy_r;
   assign bus.mem_ptr  = ptr_r;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Scoreboard bench for i2c_target_responder: a bit-banged open-drain
// controller issues directed transactions and pushes expected ACK bits,
// read bytes and written bytes into queues; a monitor process pops and
// compares whenever the target presents the corresponding output.
module tb_i2c_target_responder;
   localparam int Q = 10;
   localparam int H = 20;

   logic Pclk    = 1'b0;
   logic Presetn = 1'b0;
   logic scl_m   = 1'b1;
   logic sda_m   = 1'b1;
   int   total   = 0;
   int   bad     = 0;
   int   hi_run  = 0;
   int   hi_seen = 0;
   int   mis_drv = 0;
   logic mis_win = 1'b0;

   logic [7:0] exp_rx_q [$];
   logic [7:0] exp_rd_q [$];
   logic [7:0] obs_rd_q [$];
   logic       exp_ack_q[$];
   logic       obs_ack_q[$];

   i2c_target_responder_if #(.DATA_WIDTH(8), .MEM_DEPTH(16)) bus_if ();

   assign bus_if.scl_in = scl_m & ~bus_if.scl_oe;
   assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

   i2c_target_responder #(
      .ADDR_WIDTH(7), .DATA_WIDTH(8), .TARGET_ADDR(7'h50),
      .MEM_DEPTH(16), .STRETCH_CYCLES(8)
   ) dut (
      .Pclk    (Pclk),
      .Presetn (Presetn),
      .bus     (bus_if)
   );

   always #5 Pclk = ~Pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge Pclk);
   endtask

   task automatic scl_up();
      int guard;
      guard = 0;
      scl_m = 1'b1;
      while (bus_if.scl_in !== 1'b1 && guard < 200) begin
         @(negedge Pclk);
         guard++;
      end
      if (bus_if.scl_in !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL scl_release: SCL still low after %0d cycles, expected released", guard);
      end
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;
      wait_cyc(Q);
      scl_up();
      wait_cyc(H);
      scl_m = 1'b0;
      wait_cyc(Q);
   endtask

   task automatic read_bit(output logic v);
      sda_m = 1'b1;
      wait_cyc(Q);
      scl_up();
      wait_cyc(H / 2);
      v = bus_if.sda_in;
      wait_cyc(H / 2);
      scl_m = 1'b0;
      wait_cyc(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      wait_cyc(Q);
      scl_up();
      wait_cyc(Q);
      sda_m = 1'b0;
      wait_cyc(Q);
      scl_m = 1'b0;
      wait_cyc(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      wait_cyc(Q);
      scl_up();
      wait_cyc(Q);
      sda_m = 1'b1;
      wait_cyc(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack);
      logic a;
      exp_ack_q.push_back(exp_ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(a);
      obs_ack_q.push_back(a);
   endtask

   task automatic recv_byte(input logic [7:0] exp, input logic mack);
      logic [7:0] v;
      logic       b;
      exp_rd_q.push_back(exp);
      v = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      obs_rd_q.push_back(v);
      write_bit(mack);
   endtask

   // Monitor: pops expected values as the target produces outputs.
   always @(negedge Pclk) begin
      if (Presetn && bus_if.rx_valid) begin
         if (exp_rx_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got rx_valid with %0h, expected no write", bus_if.rx_data);
         end else begin
            chk("rx_data", 32'(bus_if.rx_data), 32'(exp_rx_q.pop_front()));
         end
      end
      if (obs_ack_q.size() > 0 && exp_ack_q.size() > 0)
         chk("ack_bit", 32'(obs_ack_q.pop_front()), 32'(exp_ack_q.pop_front()));
      if (obs_rd_q.size() > 0 && exp_rd_q.size() > 0)
         chk("rd_byte", 32'(obs_rd_q.pop_front()), 32'(exp_rd_q.pop_front()));
      if (mis_win && bus_if.sda_oe) mis_drv++;
      if (bus_if.scl_oe) begin
         hi_run++;
         hi_seen++;
      end else if (hi_run != 0) begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
         chk("stretch_len", 32'(hi_run), 32'(8));
`endif
         hi_run = 0;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      wait_cyc(4);
      chk("rst_sda_oe",   32'(bus_if.sda_oe),   32'(0));
      chk("rst_scl_oe",   32'(bus_if.scl_oe),   32'(0));
      chk("rst_busy",     32'(bus_if.busy),     32'(0));
      chk("rst_mem_ptr",  32'(bus_if.mem_ptr),  32'(0));
      chk("rst_rx_valid", 32'(bus_if.rx_valid), 32'(0));
      chk("rst_rx_data",  32'(bus_if.rx_data),  32'(0));
      Presetn = 1'b1;
      wait_cyc(5);

      // Write pointer 3 then 0x11, 0x22.
      i2c_start();
      send_byte(8'hA0, 1'b0);
      chk("busy_after_match", 32'(bus_if.busy), 32'(1));
      send_byte(8'h03, 1'b0);
      chk("ptr_after_ptr", 32'(bus_if.mem_ptr), 32'(3));
      exp_rx_q.push_back(8'h11);
      send_byte(8'h11, 1'b0);
      exp_rx_q.push_back(8'h22);
      send_byte(8'h22, 1'b0);
      i2c_stop();
      wait_cyc(5);
      chk("wr_mem_ptr", 32'(bus_if.mem_ptr), 32'(5));
      chk("busy_after_stop", 32'(bus_if.busy), 32'(0));

      // Pointer write then repeated START read.
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(8'h03, 1'b0);
      i2c_start();
      send_byte(8'hA1, 1'b0);
      chk("busy_rd", 32'(bus_if.busy), 32'(1));
      recv_byte(8'h11, 1'b0);
      recv_byte(8'h22, 1'b1);
      wait_cyc(5);
      chk("rd_released", 32'(bus_if.sda_oe), 32'(0));
      chk("rd_mem_ptr", 32'(bus_if.mem_ptr), 32'(5));
      i2c_stop();

      // Foreign address: never ACK, never busy.
      mis_win = 1'b1;
      i2c_start();
      send_byte(8'hA2, 1'b1);
      chk("mis_busy", 32'(bus_if.busy), 32'(0));
      send_byte(8'h55, 1'b1);
      i2c_stop();
      mis_win = 1'b0;
      chk("mis_sda_driven", 32'(mis_drv), 32'(0));
      chk("mis_mem_ptr", 32'(bus_if.mem_ptr), 32'(5));

      // Reset during the 4th address bit.
      i2c_start();
      write_bit(1'b1);
      write_bit(1'b0);
      write_bit(1'b1);
      sda_m = 1'b0;
      wait_cyc(Q);
      scl_up();
      wait_cyc(H / 2);
      Presetn = 1'b0;
      #1;
      chk("midrst_sda_oe",  32'(bus_if.sda_oe),  32'(0));
      chk("midrst_busy",    32'(bus_if.busy),    32'(0));
      chk("midrst_mem_ptr", 32'(bus_if.mem_ptr), 32'(0));
      sda_m = 1'b1;
      scl_m = 1'b1;
      wait_cyc(4);
      Presetn = 1'b1;
      wait_cyc(5);

      // Pointer wrap: 0x0F then 0xAA, 0xBB.
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(8'h0F, 1'b0);
      exp_rx_q.push_back(8'hAA);
      send_byte(8'hAA, 1'b0);
      exp_rx_q.push_back(8'hBB);
      send_byte(8'hBB, 1'b0);
      i2c_stop();
      wait_cyc(5);
      chk("wrap_mem_ptr", 32'(bus_if.mem_ptr), 32'(1));

      // Read back across the wrap.
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(8'h0F, 1'b0);
      i2c_start();
      send_byte(8'hA1, 1'b0);
      recv_byte(8'hAA, 1'b0);
      recv_byte(8'hBB, 1'b1);
      i2c_stop();
      wait_cyc(5);
      chk("wrap_rd_ptr", 32'(bus_if.mem_ptr), 32'(1));

      // Memory survived reset and the foreign-address traffic.
      i2c_start();
      send_byte(8'hA0, 1'b0);
      send_byte(8'h03, 1'b0);
      i2c_start();
      send_byte(8'hA1, 1'b0);
      recv_byte(8'h11, 1'b0);
      recv_byte(8'h22, 1'b1);
      i2c_stop();
      wait_cyc(20);
      chk("keep_mem_ptr", 32'(bus_if.mem_ptr), 32'(5));

      chk("rx_drained",  32'(exp_rx_q.size()),  32'(0));
      chk("ack_drained", 32'(exp_ack_q.size()), 32'(0));
      chk("rd_drained",  32'(exp_rd_q.size()),  32'(0));
`ifdef I2C_TARGET_CLK_STRETCH_EN
      chk("stretch_seen", 32'(hi_seen != 0), 32'(1));
`else
      chk("scl_never_driven", 32'(hi_seen), 32'(0));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
